// File: rtl/sha256_msg_schedule_if.sv
// Bus bundle for the SHA-256 message-schedule stage: block intake on one side,
// per-round W/K stream toward the compressor on the other.
interface sha256_msg_schedule_if;
   logic         block_valid;
   logic         block_ready;
   logic [511:0] block_data;
   logic         abort;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_data;
   logic [31:0]  k_out;
   logic [5:0]   round_idx;
   logic         first_round;
   logic         last_round;

   modport master (
      output block_valid, block_data, abort, w_ready,
      input  block_ready, w_valid, w_data, k_out, round_idx, first_round, last_round
   );

   modport slave (
      input  block_valid, block_data, abort, w_ready,
      output block_ready, w_valid, w_data, k_out, round_idx, first_round, last_round
   );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into 64 W[t] words using a
// 16-word sliding window, paired with the round constant K[t].
module sha256_msg_schedule (
   input  logic                         clk,
   input  logic                         reset_n,
   sha256_msg_schedule_if.slave         bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]  state;
   logic [5:0]  round;
   logic [31:0] window [16];
   logic [31:0] next_word;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   function automatic logic [31:0] k_rom(input logic [5:0] idx);
      k_rom = 32'h0;
      case (idx)
         6'd0:  k_rom = 32'h428a2f98;  6'd1:  k_rom = 32'h71374491;
         6'd2:  k_rom = 32'hb5c0fbcf;  6'd3:  k_rom = 32'he9b5dba5;
         6'd4:  k_rom = 32'h3956c25b;  6'd5:  k_rom = 32'h59f111f1;
         6'd6:  k_rom = 32'h923f82a4;  6'd7:  k_rom = 32'hab1c5ed5;
         6'd8:  k_rom = 32'hd807aa98;  6'd9:  k_rom = 32'h12835b01;
         6'd10: k_rom = 32'h243185be;  6'd11: k_rom = 32'h550c7dc3;
         6'd12: k_rom = 32'h72be5d74;  6'd13: k_rom = 32'h80deb1fe;
         6'd14: k_rom = 32'h9bdc06a7;  6'd15: k_rom = 32'hc19bf174;
         6'd16: k_rom = 32'he49b69c1;  6'd17: k_rom = 32'hefbe4786;
         6'd18: k_rom = 32'h0fc19dc6;  6'd19: k_rom = 32'h240ca1cc;
         6'd20: k_rom = 32'h2de92c6f;  6'd21: k_rom = 32'h4a7484aa;
         6'd22: k_rom = 32'h5cb0a9dc;  6'd23: k_rom = 32'h76f988da;
         6'd24: k_rom = 32'h983e5152;  6'd25: k_rom = 32'ha831c66d;
         6'd26: k_rom = 32'hb00327c8;  6'd27: k_rom = 32'hbf597fc7;
         6'd28: k_rom = 32'hc6e00bf3;  6'd29: k_rom = 32'hd5a79147;
         6'd30: k_rom = 32'h06ca6351;  6'd31: k_rom = 32'h14292967;
         6'd32: k_rom = 32'h27b70a85;  6'd33: k_rom = 32'h2e1b2138;
         6'd34: k_rom = 32'h4d2c6dfc;  6'd35: k_rom = 32'h53380d13;
         6'd36: k_rom = 32'h650a7354;  6'd37: k_rom = 32'h766a0abb;
         6'd38: k_rom = 32'h81c2c92e;  6'd39: k_rom = 32'h92722c85;
         6'd40: k_rom = 32'ha2bfe8a1;  6'd41: k_rom = 32'ha81a664b;
         6'd42: k_rom = 32'hc24b8b70;  6'd43: k_rom = 32'hc76c51a3;
         6'd44: k_rom = 32'hd192e819;  6'd45: k_rom = 32'hd6990624;
         6'd46: k_rom = 32'hf40e3585;  6'd47: k_rom = 32'h106aa070;
         6'd48: k_rom = 32'h19a4c116;  6'd49: k_rom = 32'h1e376c08;
         6'd50: k_rom = 32'h2748774c;  6'd51: k_rom = 32'h34b0bcb5;
         6'd52: k_rom = 32'h391c0cb3;  6'd53: k_rom = 32'h4ed8aa4a;
         6'd54: k_rom = 32'h5b9cca4f;  6'd55: k_rom = 32'h682e6ff3;
         6'd56: k_rom = 32'h748f82ee;  6'd57: k_rom = 32'h78a5636f;
         6'd58: k_rom = 32'h84c87814;  6'd59: k_rom = 32'h8cc70208;
         6'd60: k_rom = 32'h90befffa;  6'd61: k_rom = 32'ha4506ceb;
         6'd62: k_rom = 32'hbef9a3f7;  6'd63: k_rom = 32'hc67178f2;
      endcase
   endfunction

   // window[0] is the word being presented; this is W[t+16] for the current t
   assign next_word = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];

   // Abort outranks both block intake and a same-cycle transfer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         round <= '0;
         for (int i = 0; i < 16; i++) window[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.abort && bus.block_valid) begin
                  for (int i = 0; i < 16; i++) window[i] <= bus.block_data[511 - 32*i -: 32];
                  round <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (bus.abort) begin
                  round <= '0;
                  state <= IDLE;
               end else if (bus.w_ready) begin
                  for (int i = 0; i < 15; i++) window[i] <= window[i+1];
                  window[15] <= next_word;
                  round      <= round + 6'd1;
                  if (round == 6'd63) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.block_ready = (state == IDLE);
   assign bus.w_valid     = (state == RUN);
   assign bus.w_data      = window[0];
   assign bus.k_out       = k_rom(round);
   assign bus.round_idx   = round;
   assign bus.first_round = (state == RUN) && (round == 6'd0);
   assign bus.last_round  = (state == RUN) && (round == 6'd63);
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: a reference schedule model fills a
// scoreboard on block acceptance, entries are compared and popped per transfer.
module tb_sha256_msg_schedule;
   logic clk;
   logic reset_n;

   sha256_msg_schedule_if bus ();

   sha256_msg_schedule dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef struct {
      logic [31:0] w;
      logic [31:0] k;
      logic [5:0]  idx;
      bit          abc;
   } exp_t;

   exp_t         sb [$];
   int           compared;
   int           mismatched;
   int           ready_pct;
   int           since;
   bit           pend_valid;
   logic [511:0] pend_data;
   logic [511:0] abc_block;
   logic [511:0] alt_block;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_block(input logic [511:0] data);
      logic [31:0] w [64];
      exp_t        e;
      for (int t = 0; t < 16; t++) w[t] = data[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10))
              + w[t-7]
              + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
              + w[t-16];
      end
      for (int t = 0; t < 64; t++) begin
         e.w   = w[t];
         e.k   = K_TAB[t];
         e.idx = 6'(t);
         e.abc = (data === abc_block);
         sb.push_back(e);
      end
   endtask

   // Called at a falling edge: check outputs against the scoreboard, drive the next inputs
   task automatic step(input bit ab);
      exp_t e;
      bit   xfer;
      check("w_valid", 32'(bus.w_valid), 32'(sb.size() > 0));
      check("block_ready", 32'(bus.block_ready), 32'(sb.size() == 0));
      if (sb.size() > 0) begin
         e = sb[0];
         check("w_data", bus.w_data, e.w);
         check("k_out", bus.k_out, e.k);
         check("round_idx", 32'(bus.round_idx), 32'(e.idx));
         check("first_round", 32'(bus.first_round), 32'(e.idx == 6'd0));
         check("last_round", 32'(bus.last_round), 32'(e.idx == 6'd63));
         if (e.abc && e.idx == 6'd0) begin
            check("abc_w0", bus.w_data, 32'h61626380);
            check("abc_k0", bus.k_out, 32'h428a2f98);
         end
         if (e.abc && e.idx == 6'd15) check("abc_w15", bus.w_data, 32'h00000018);
         if (e.abc && e.idx == 6'd16) check("abc_w16", bus.w_data, 32'h61626380);
         if (e.abc && e.idx == 6'd17) check("abc_w17", bus.w_data, 32'h000f0000);
         if (e.abc && e.idx == 6'd63) check("abc_k63", bus.k_out, 32'hc67178f2);
      end else begin
         check("idle_first", 32'(bus.first_round), 32'd0);
         check("idle_last", 32'(bus.last_round), 32'd0);
      end
      if (ready_pct == 100 && since == 64) check("ready_latency", 32'(bus.block_ready), 32'd1);

      bus.abort       = ab;
      bus.w_ready     = ($urandom_range(0, 99) < ready_pct);
      bus.block_valid = pend_valid;
      bus.block_data  = pend_data;
      xfer = bus.w_valid && bus.w_ready && !ab;
      if (ab) sb.delete();
      else if (xfer) void'(sb.pop_front());
      else if (bus.block_ready && pend_valid && reset_n) begin
         push_block(pend_data);
         pend_valid = 1'b0;
         since      = -1;
      end
      @(negedge clk);
      since++;
   endtask

   task automatic run_until_idle();
      bit done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         step(1'b0);
         if (sb.size() == 0) done = 1'b1;
      end
      check("idle_timeout", 32'(done), 32'd1);
   endtask

   task automatic run_until_round(input int n);
      bit found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (sb.size() > 0 && int'(sb[0].idx) == n && bus.w_valid) found = 1'b1;
         else step(1'b0);
      end
      check("round_timeout", 32'(found), 32'd1);
   endtask

   task automatic applyStimulus(input logic [511:0] data);
      pend_data  = data;
      pend_valid = 1'b1;
   endtask

   initial begin
      compared        = 0;
      mismatched      = 0;
      ready_pct       = 100;
      since           = 1000;
      pend_valid      = 1'b0;
      pend_data       = '0;
      abc_block       = {32'h61626380, 448'h0, 32'h00000018};
      for (int i = 0; i < 16; i++) alt_block[511 - 32*i -: 32] = 32'hdeadbeef ^ (32'h01010101 * i);
      reset_n         = 1'b0;
      bus.block_valid = 1'b0;
      bus.block_data  = '0;
      bus.abort       = 1'b0;
      bus.w_ready     = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_w_data", bus.w_data, 32'd0);
      check("rst_round_idx", 32'(bus.round_idx), 32'd0);
      step(1'b0);
      reset_n = 1'b1;
      step(1'b0);

      // "abc" block at full rate
      $display("[TB] abc block, full rate");
      applyStimulus(abc_block);
      run_until_idle();
      step(1'b0);

      // Same block with random back-pressure
      $display("[TB] abc block, 50%% ready");
      ready_pct = 50;
      applyStimulus(abc_block);
      run_until_idle();
      ready_pct = 100;
      step(1'b0);

      // block_valid held through RUN with different data
      $display("[TB] block_valid held through RUN");
      applyStimulus(abc_block);
      step(1'b0);
      applyStimulus(alt_block);
      run_until_idle();
      step(1'b0);

      // Abort at round 20, then abort in IDLE blocking an offered block
      $display("[TB] abort at round 20");
      applyStimulus(abc_block);
      run_until_round(20);
      step(1'b1);
      applyStimulus(alt_block);
      step(1'b1);
      run_until_idle();
      step(1'b0);

      // Asynchronous reset mid-cycle at round 40
      $display("[TB] reset at round 40");
      applyStimulus(abc_block);
      run_until_round(40);
      #2 reset_n = 1'b0;
      #1;
      check("arst_w_valid", 32'(bus.w_valid), 32'd0);
      check("arst_block_ready", 32'(bus.block_ready), 32'd1);
      check("arst_round_idx", 32'(bus.round_idx), 32'd0);
      check("arst_w_data", bus.w_data, 32'd0);
      sb.delete();
      @(negedge clk);
      step(1'b0);
      reset_n = 1'b1;
      applyStimulus(abc_block);
      run_until_idle();
      step(1'b0);

      // All-zero block
      $display("[TB] all-zero block");
      applyStimulus('0);
      run_until_idle();
      step(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
